regs_sb: RTL and testbench
==========================

Name: regs_sb

Overview:
- Parametrised successor to the two-entry operand register block: NUM_REGS × DATA_W register file with an instruction decoder.
- Sits between the instruction source and the arithmetic units. Issues operand pairs to an ALU and accepts tagged write-back results.
- A per-register busy scoreboard stalls hazardous instructions through a valid/ready handshake.
- Supports multiple ALU operations in flight, provided they target distinct registers.

Parameters:
- NUM_REGS, 4: number of registers. Must be a power of two, ≥2.
- DATA_W, 8: register/data width.
- Derived (localparam): ADDR_W = clog2(NUM_REGS).
- Derived (localparam): INSTR_W = 2 + 2*ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- main_enable  in  1  global enable. When 0, no instruction is accepted; write-backs still complete.
- instr  in  INSTR_W  instruction = {op[1:0], ra[ADDR_W-1:0], rb[ADDR_W-1:0]}.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  instruction accepted this cycle when instr_valid && instr_ready (combinational).
- data_in  in  DATA_W  immediate for LOAD.
- alu_valid  out  1  operand pair issued (registered, 1-cycle pulse per issue).
- op_a  out  DATA_W  operand A (registered).
- op_b  out  DATA_W  operand B (registered).
- alu_tag  out  ADDR_W  destination register for the result (registered).
- res_valid  in  1  ALU result returning.
- res_tag  in  ADDR_W  destination of the returning result.
- res_data  in  DATA_W  result value.
- rd_addr  in  ADDR_W  debug read address.
- rd_data  out  DATA_W  regs[rd_addr], combinational.
- busy  out  NUM_REGS  scoreboard bits.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst==0 at clk edge):
  - all regs = 0, busy = 0, alu_valid = 0, op_a = 0, op_b = 0, alu_tag = 0, err = 0.
  - res_valid, instr_valid and any in-flight results are ignored/dropped. Reset mid-flight leaves no busy bit set.
- Opcodes:
  - 00 NOP: accepted, no effect.
  - 01 LOAD: regs[ra] <= data_in.
  - 10 ISSUE: op_a <= regs[ra], op_b <= regs[rb], alu_tag <= ra, alu_valid <= 1, busy[ra] <= 1.
  - 11 CLR: regs[ra] <= 0.
- Hazard/ready:
  - instr_ready = main_enable && !hazard.
  - hazard (all evaluated on current registered busy):
    - LOAD/CLR: busy[ra].
    - ISSUE: busy[ra] || busy[rb].
    - NOP: never.
  - A result retiring in the same cycle does not clear the hazard; the instruction is accepted the following cycle (one-cycle penalty, no bypass).
  - ISSUE with ra==rb is legal: both operands equal regs[ra].
- Issue latency: accepted on edge N → alu_valid, op_a, op_b, alu_tag valid after edge N; alu_valid falls after N+1 unless another ISSUE is accepted. Back-to-back issues allowed on independent registers.
- Write-back: res_valid with busy[res_tag]==1 → regs[res_tag] <= res_data, busy[res_tag] <= 0 on the same edge.
- Error:
  - res_valid with busy[res_tag]==0 → write suppressed, err <= 1.
  - err is cleared only by reset.
- Simultaneous events:
  - Accepted LOAD/CLR and write-back in the same cycle target different regs by construction; both take effect.
  - Accepted ISSUE setting busy[x] and write-back clearing busy[y], x≠y: both take effect.
- Read port: rd_data reflects the register state after the most recent edge (no write-through).
- main_enable = 0: instr_ready = 0, alu_valid deasserts next edge, write-backs and err logic unaffected.

Test Plan:
- Reset, LOAD r0 = 8'h01, LOAD r1 = 8'h11, ISSUE ra=0 rb=1 → next cycle alu_valid=1, op_a=8'h01, op_b=8'h11, alu_tag=0, busy=4'b0001. Then res_valid, tag 0, data 8'h12 → regs[0]=8'h12, busy=0.
- Hazard: after ISSUE ra=0, present ISSUE ra=1 rb=0 → instr_ready=0 until the cycle after res_valid (tag 0) retires, then accepted with op_b = returned value.
- Independent back-to-back: ISSUE ra=2 rb=3 then ISSUE ra=1 rb=0 on consecutive cycles → alu_valid high 2 cycles, busy=4'b0110. Out-of-order results (tag 1 then tag 2) both written.
- Reset mid-flight: ISSUE ra=0, then rst=0 one cycle → busy=0, regs=0, alu_valid=0. A later res_valid tag 0 sets err=1 and regs[0] stays 0.
- main_enable=0 with instr_valid=1 LOAD → instr_ready=0, regs unchanged. A concurrent pending result still retires.
- NUM_REGS=8, DATA_W=16 instance: LOAD r7=16'hBEEF, CLR r7 → rd_data(7) reads 16'hBEEF then 16'h0000. ISSUE ra=rb=5 → op_a = op_b = regs[5].

Source files
------------

// File: rtl/regs_sb.sv
// Register file with operand issue, tagged write-back and a per-register busy
// scoreboard that holds off instructions touching registers awaiting a result.
module regs_sb #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  localparam int INSTR_W = 2 + 2 * ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                main_enable,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [DATA_W-1:0]   data_in,
  output logic                alu_valid,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [ADDR_W-1:0]   alu_tag,
  input  logic                res_valid,
  input  logic [ADDR_W-1:0]   res_tag,
  input  logic [DATA_W-1:0]   res_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [NUM_REGS-1:0] busy,
  output logic                err
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_ISSUE = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  logic [DATA_W-1:0]   regs_reg  [NUM_REGS];
  logic [DATA_W-1:0]   regs_next [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg, busy_next;
  logic                err_reg;
  logic                alu_valid_reg;
  logic [DATA_W-1:0]   op_a_reg, op_b_reg;
  logic [ADDR_W-1:0]   alu_tag_reg;

  logic [1:0]        op;
  logic [ADDR_W-1:0] ra, rb;
  logic              hazard, accept;
  logic              do_load, do_clr, do_issue;
  logic              wb_hit, wb_miss;

  assign op = instr[INSTR_W-1 -: 2];
  assign ra = instr[2*ADDR_W-1 -: ADDR_W];
  assign rb = instr[ADDR_W-1:0];

  // Hazards look only at the registered busy bits: a result retiring this
  // cycle unblocks the waiting instruction one cycle later (no bypass).
  always_comb begin
    hazard = 1'b0;
    case (op)
      OP_LOAD, OP_CLR: hazard = busy_reg[ra];
      OP_ISSUE:        hazard = busy_reg[ra] | busy_reg[rb];
      default:         hazard = 1'b0;
    endcase
  end

  assign instr_ready = main_enable && !hazard;
  assign accept      = instr_valid && instr_ready;
  assign do_load     = accept && (op == OP_LOAD);
  assign do_clr      = accept && (op == OP_CLR);
  assign do_issue    = accept && (op == OP_ISSUE);
  assign wb_hit      = res_valid &&  busy_reg[res_tag];
  assign wb_miss     = res_valid && !busy_reg[res_tag];

  // An accepted instruction never targets a busy register while a write-back
  // always does, so the per-register updates below cannot collide.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic wb_sel, ra_sel;
      assign wb_sel = wb_hit && (res_tag == IDX);
      assign ra_sel = (ra == IDX);
      assign busy_next[gi] = (busy_reg[gi] && !wb_sel) || (do_issue && ra_sel);
      assign regs_next[gi] = wb_sel             ? res_data :
                             (do_load && ra_sel) ? data_in  :
                             (do_clr  && ra_sel) ? '0       : regs_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= regs_next[i];
      busy_reg <= busy_next;
      if (wb_miss) err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_valid_reg <= 1'b0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      alu_tag_reg   <= '0;
    end else begin
      alu_valid_reg <= do_issue;
      if (do_issue) begin
        op_a_reg    <= regs_reg[ra];
        op_b_reg    <= regs_reg[rb];
        alu_tag_reg <= ra;
      end
    end
  end

  assign alu_valid = alu_valid_reg;
  assign op_a      = op_a_reg;
  assign op_b      = op_b_reg;
  assign alu_tag   = alu_tag_reg;
  assign rd_data   = regs_reg[rd_addr];
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_regs_sb.sv
// Bench for regs_sb: directed scenarios plus random traffic on a 4x8 instance
// checked every cycle against a behavioural model; directed checks on 8x16.
module tb_regs_sb;
  localparam int NR = 4, DW = 8, AW = 2, IW = 6;
  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, ISSUE = 2'b10, CLR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, main_enable = 1'b1, instr_valid = 1'b0, res_valid = 1'b0;
  logic [IW-1:0] instr = '0;
  logic [DW-1:0] data_in = '0, res_data = '0;
  logic [AW-1:0] res_tag = '0, rd_addr = '0;
  logic          instr_ready, alu_valid, err;
  logic [DW-1:0] op_a, op_b, rd_data;
  logic [AW-1:0] alu_tag;
  logic [NR-1:0] busy;

  regs_sb #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .main_enable(main_enable), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .data_in(data_in),
    .alu_valid(alu_valid), .op_a(op_a), .op_b(op_b), .alu_tag(alu_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .err(err)
  );

  logic        b_rst = 1'b0, b_instr_valid = 1'b0, b_res_valid = 1'b0;
  logic [7:0]  b_instr = '0;
  logic [15:0] b_data_in = '0, b_res_data = '0;
  logic [2:0]  b_res_tag = '0, b_rd_addr = '0;
  logic        b_instr_ready, b_alu_valid, b_err;
  logic [15:0] b_op_a, b_op_b, b_rd_data;
  logic [2:0]  b_alu_tag;
  logic [7:0]  b_busy;

  regs_sb #(.NUM_REGS(8), .DATA_W(16)) dut_b (
    .clk(clk), .rst(b_rst), .main_enable(1'b1), .instr(b_instr),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .data_in(b_data_in),
    .alu_valid(b_alu_valid), .op_a(b_op_a), .op_b(b_op_b), .alu_tag(b_alu_tag),
    .res_valid(b_res_valid), .res_tag(b_res_tag), .res_data(b_res_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .busy(b_busy), .err(b_err)
  );

  int checks = 0, errors = 0;
  logic cmp_on = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: register values, pending-result set, error flag, last issue.
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic          m_err, m_av;
  logic [DW-1:0] m_a, m_b;
  logic [AW-1:0] m_tag;

  function automatic logic m_ready(logic [IW-1:0] ins, logic en);
    logic [NR-1:0] touched;
    touched = '0;
    if (ins[5:4] != NOP)   touched[ins[3:2]] = 1'b1;
    if (ins[5:4] == ISSUE) touched[ins[1:0]] = 1'b1;
    return en && ((touched & m_busy) == '0);
  endfunction

  always @(posedge clk) begin : model
    logic          acc;
    logic [NR-1:0] pending;
    if (!rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_busy = '0; m_err = 0; m_av = 0; m_a = '0; m_b = '0; m_tag = '0;
    end else begin
      acc     = instr_valid && m_ready(instr, main_enable);
      pending = m_busy;
      m_av    = 1'b0;
      if (res_valid) begin
        if (pending[res_tag]) begin
          m_regs[res_tag] = res_data;
          m_busy[res_tag] = 1'b0;
        end else m_err = 1'b1;
      end
      if (acc) begin
        case (instr[5:4])
          LOAD:  m_regs[instr[3:2]] = data_in;
          CLR:   m_regs[instr[3:2]] = '0;
          ISSUE: begin
            m_av = 1'b1; m_a = m_regs[instr[3:2]]; m_b = m_regs[instr[1:0]];
            m_tag = instr[3:2]; m_busy[instr[3:2]] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("busy", busy, m_busy);
      check("err", err, m_err);
      check("alu_valid", alu_valid, m_av);
      check("op_a", op_a, m_a);
      check("op_b", op_b, m_b);
      check("alu_tag", alu_tag, m_tag);
      check("instr_ready", instr_ready, m_ready(instr, main_enable));
      check("rd_data", rd_data, m_regs[rd_addr]);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic put(logic [1:0] op, logic [AW-1:0] ra, logic [AW-1:0] rb, logic [DW-1:0] d);
    instr = {op, ra, rb}; data_in = d; instr_valid = 1'b1;
  endtask

  task automatic ret(logic [AW-1:0] t, logic [DW-1:0] d);
    res_valid = 1'b1; res_tag = t; res_data = d;
  endtask

  initial begin
    int t;
    step(); cmp_on = 1'b1; step(); rst = 1'b1;
    check("rst_busy", busy, 0); check("rst_alu_valid", alu_valid, 0); check("rst_err", err, 0);

    // basic load / issue / write-back
    put(LOAD, 0, 0, 8'h01); step();
    put(LOAD, 1, 0, 8'h11); step();
    put(ISSUE, 0, 1, 8'h00); step(); instr_valid = 1'b0;
    check("t1_alu_valid", alu_valid, 1); check("t1_op_a", op_a, 8'h01);
    check("t1_op_b", op_b, 8'h11); check("t1_tag", alu_tag, 0); check("t1_busy", busy, 4'b0001);
    ret(0, 8'h12); step(); res_valid = 1'b0; rd_addr = 0; #1;
    check("t1_r0", rd_data, 8'h12); check("t1_busy_clr", busy, 0); check("t1_av_low", alu_valid, 0);

    // hazard stall with one-cycle retire penalty
    put(ISSUE, 0, 0, 0); step();
    put(ISSUE, 1, 0, 0); #1; check("hz_stall0", instr_ready, 0);
    step(); #1; check("hz_stall1", instr_ready, 0);
    ret(0, 8'h55); #1; check("hz_retire_cycle", instr_ready, 0);
    step(); res_valid = 1'b0; #1; check("hz_released", instr_ready, 1);
    step(); instr_valid = 1'b0;
    check("hz_op_a", op_a, 8'h11); check("hz_op_b", op_b, 8'h55);
    check("hz_tag", alu_tag, 1); check("hz_busy", busy, 4'b0010);
    ret(1, 8'h66); step(); res_valid = 1'b0;

    // independent back-to-back issues, results returned out of order
    put(ISSUE, 2, 3, 0); step();
    check("bb_av0", alu_valid, 1); check("bb_tag0", alu_tag, 2);
    put(ISSUE, 1, 0, 0); step(); instr_valid = 1'b0;
    check("bb_av1", alu_valid, 1); check("bb_tag1", alu_tag, 1); check("bb_busy", busy, 4'b0110);
    check("bb_op_b", op_b, 8'h55);
    ret(1, 8'hA1); step(); ret(2, 8'hA2); step(); res_valid = 1'b0;
    check("bb_busy_clr", busy, 0);
    rd_addr = 1; #1; check("bb_r1", rd_data, 8'hA1);
    rd_addr = 2; #1; check("bb_r2", rd_data, 8'hA2);

    // reset mid-flight, late result flags an error
    put(ISSUE, 0, 0, 0); step(); instr_valid = 1'b0; rst = 1'b0; step(); rst = 1'b1;
    rd_addr = 0; #1;
    check("rm_busy", busy, 0); check("rm_av", alu_valid, 0); check("rm_r0", rd_data, 0);
    ret(0, 8'h77); step(); res_valid = 1'b0; #1;
    check("rm_err", err, 1); check("rm_r0_kept", rd_data, 0);
    step(); check("rm_err_sticky", err, 1);
    rst = 1'b0; step(); rst = 1'b1; check("rm_err_clr", err, 0);

    // disabled: nothing accepted, pending result still retires
    put(ISSUE, 2, 2, 0); step();
    main_enable = 1'b0; put(LOAD, 3, 0, 8'hEE); ret(2, 8'h33); #1;
    check("en_ready", instr_ready, 0);
    step(); res_valid = 1'b0; instr_valid = 1'b0;
    check("en_busy", busy, 0); check("en_av", alu_valid, 0);
    rd_addr = 3; #1; check("en_r3", rd_data, 0);
    rd_addr = 2; #1; check("en_r2", rd_data, 8'h33);
    main_enable = 1'b1;

    // random traffic; results returned mostly for pending registers
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) != 0);
      main_enable = ($urandom_range(0, 7) != 0);
      instr_valid = ($urandom_range(0, 3) != 0);
      instr       = IW'($urandom);
      data_in     = DW'($urandom);
      rd_addr     = AW'($urandom);
      res_data    = DW'($urandom);
      if (m_busy != '0 && $urandom_range(0, 1) == 1) begin
        do t = $urandom_range(0, NR - 1); while (!m_busy[t]);
        res_valid = 1'b1; res_tag = AW'(t);
      end else begin
        res_valid = ($urandom_range(0, 63) == 0);
        res_tag   = AW'($urandom);
      end
      step();
    end
    rst = 1'b1; instr_valid = 1'b0; res_valid = 1'b0; step();

    // wider instance
    b_rst = 1'b1;
    b_instr = {LOAD, 3'd7, 3'd0}; b_data_in = 16'hBEEF; b_instr_valid = 1'b1; step();
    b_rd_addr = 3'd7; #1; check("w_r7_load", b_rd_data, 16'hBEEF);
    b_instr = {CLR, 3'd7, 3'd0}; step(); #1; check("w_r7_clr", b_rd_data, 16'h0000);
    b_instr = {LOAD, 3'd5, 3'd0}; b_data_in = 16'h1234; step();
    b_instr = {ISSUE, 3'd5, 3'd5}; step(); b_instr_valid = 1'b0;
    check("w_av", b_alu_valid, 1); check("w_op_a", b_op_a, 16'h1234);
    check("w_op_b", b_op_b, 16'h1234); check("w_tag", b_alu_tag, 5); check("w_busy", b_busy, 8'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
